// File: rtl/pb_fb_arbiter_pkg.sv
// Shared definitions for the frontend M-Bus arbiter.
//   NCPU_AW / NCPU_DW : CPU address / data widths of the M-Bus
//   NCPU_BW           : byte-lane count (width of a write mask)
//   arb_state_t       : arbiter FSM state encoding
package pb_fb_arbiter_pkg;

    localparam int NCPU_AW = 32;
    localparam int NCPU_DW = 32;
    localparam int NCPU_BW = NCPU_DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pb_fb_rr_arb.sv
// Round-robin pick: one-hot grant of the first requester at or after ptr,
// wrapping modulo NMST.
//   req : request vector, one bit per master
//   ptr : binary index of the highest-priority master
//   gnt : one-hot grant (all zero when nothing is requested)
module pb_fb_rr_arb #(
    parameter int NMST = 2
) (
    input  logic [NMST-1:0]         req,
    input  logic [$clog2(NMST)-1:0] ptr,
    output logic [NMST-1:0]         gnt
);

    localparam int PW = $clog2(NMST);

    logic [NMST-1:0] hi_mask;
    logic [NMST-1:0] req_hi;
    logic [NMST-1:0] hi_first;
    logic [NMST-1:0] lo_first;

    // Requests at or above ptr win first; if there are none the search
    // wraps around to the lowest-numbered requester overall.
    genvar gi;
    generate
        for (gi = 0; gi < NMST; gi++) begin : g_pick
            assign hi_mask[gi] = (PW'(gi) >= ptr);
            assign req_hi[gi]  = req[gi] & hi_mask[gi];
            if (gi == 0) begin : g_first
                assign hi_first[gi] = req_hi[gi];
                assign lo_first[gi] = req[gi];
            end else begin : g_rest
                assign hi_first[gi] = req_hi[gi] & ~(|req_hi[gi-1:0]);
                assign lo_first[gi] = req[gi] & ~(|req[gi-1:0]);
            end
        end
    endgenerate

    assign gnt = (|req_hi) ? hi_first : lo_first;

endmodule

// File: rtl/pb_fb_arbiter.sv
// Shares one frontend M-Bus among NMST masters, one transaction at a time.
// IDLE picks a master round-robin (one-cycle bubble), CMD forwards its
// command to the bus, DATA routes the bus response back to it.
//   clk, rst                 : clock, synchronous active-high reset
//   m_cmd_* / m_din          : per-master command channels (flattened)
//   m_valid / m_ready/m_dout : per-master response channels
//   fb_mbus_cmd_* / fb_mbus_din      : downstream command channel
//   fb_mbus_valid/ready/dout         : downstream response channel
module pb_fb_arbiter
    import pb_fb_arbiter_pkg::*;
#(
    parameter int NMST = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NMST-1:0]         m_cmd_valid,
    output logic [NMST-1:0]         m_cmd_ready,
    input  logic [NMST*NCPU_AW-1:0] m_cmd_addr,
    input  logic [NMST*NCPU_BW-1:0] m_cmd_we_msk,
    input  logic [NMST*NCPU_DW-1:0] m_din,
    output logic [NMST-1:0]         m_valid,
    input  logic [NMST-1:0]         m_ready,
    output logic [NMST*NCPU_DW-1:0] m_dout,
    output logic                    fb_mbus_cmd_valid,
    input  logic                    fb_mbus_cmd_ready,
    output logic [NCPU_AW-1:0]      fb_mbus_cmd_addr,
    output logic [NCPU_BW-1:0]      fb_mbus_cmd_we_msk,
    output logic [NCPU_DW-1:0]      fb_mbus_din,
    input  logic                    fb_mbus_valid,
    output logic                    fb_mbus_ready,
    input  logic [NCPU_DW-1:0]      fb_mbus_dout
);

    localparam int GW = $clog2(NMST);
    localparam logic [GW-1:0] LAST_IDX = GW'(NMST - 1);

    arb_state_t      state_reg;
    logic [GW-1:0]   ptr_reg;
    logic [GW-1:0]   grant_reg;
    logic [NMST-1:0] pick_oh;
    logic [GW-1:0]   pick_idx;
    logic [NMST-1:0] grant_oh;
    logic [GW-1:0]   ptr_next;
    logic            in_cmd;
    logic            in_data;
    logic            busy;
    logic            sel_cmd_valid;
    logic            sel_ready;

    logic [NCPU_AW-1:0] addr_arr [NMST];
    logic [NCPU_BW-1:0] we_arr   [NMST];
    logic [NCPU_DW-1:0] din_arr  [NMST];

    pb_fb_rr_arb #(.NMST(NMST)) u_rr_arb (
        .req (m_cmd_valid),
        .ptr (ptr_reg),
        .gnt (pick_oh)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NMST; i++) begin
            if (pick_oh[i]) begin
                pick_idx = GW'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NMST; gi++) begin : g_slice
            assign addr_arr[gi] = m_cmd_addr[gi*NCPU_AW +: NCPU_AW];
            assign we_arr[gi]   = m_cmd_we_msk[gi*NCPU_BW +: NCPU_BW];
            assign din_arr[gi]  = m_din[gi*NCPU_DW +: NCPU_DW];
            // Response data is broadcast; m_valid selects the owner.
            assign m_dout[gi*NCPU_DW +: NCPU_DW] = in_data ? fb_mbus_dout : '0;
        end
    endgenerate

    assign grant_oh      = {{(NMST-1){1'b0}}, 1'b1} << grant_reg;
    assign in_cmd        = (state_reg == ST_CMD);
    assign in_data       = (state_reg == ST_DATA);
    assign busy          = in_cmd | in_data;
    assign sel_cmd_valid = m_cmd_valid[grant_reg];
    assign sel_ready     = m_ready[grant_reg];
    assign ptr_next      = (grant_reg == LAST_IDX) ? '0 : grant_reg + GW'(1);

    // Handshakes pass straight through to the granted master so that each
    // phase can complete in a single cycle.
    assign fb_mbus_cmd_valid  = in_cmd & sel_cmd_valid;
    assign fb_mbus_cmd_addr   = busy ? addr_arr[grant_reg] : '0;
    assign fb_mbus_cmd_we_msk = busy ? we_arr[grant_reg]   : '0;
    assign fb_mbus_din        = busy ? din_arr[grant_reg]  : '0;
    assign m_cmd_ready        = (in_cmd & fb_mbus_cmd_ready) ? grant_oh : '0;
    assign fb_mbus_ready      = in_data & sel_ready;
    assign m_valid            = (in_data & fb_mbus_valid) ? grant_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            grant_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|m_cmd_valid) begin
                        grant_reg <= pick_idx;
                        state_reg <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // A master that withdraws loses its turn without moving
                    // the pointer, so it keeps priority on its next request.
                    if (!sel_cmd_valid) begin
                        state_reg <= ST_IDLE;
                    end else if (fb_mbus_cmd_ready) begin
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (fb_mbus_valid && sel_ready) begin
                        ptr_reg   <= ptr_next;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        (state_reg != ST_IDLE) |-> $onehot(grant_oh));
    a_valid_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(m_valid));
`endif

endmodule

// File: tb/tb_pb_fb_arbiter.sv
module tb_pb_fb_arbiter;
    import pb_fb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Two-master instance (scoreboarded)
    logic [1:0]  m_cmd_valid, m_cmd_ready, m_valid, m_ready;
    logic [63:0] m_cmd_addr, m_din, m_dout;
    logic [7:0]  m_cmd_we_msk;
    logic        fb_cmd_valid, fb_cmd_ready, fb_valid, fb_ready;
    logic [31:0] fb_cmd_addr, fb_din, fb_dout;
    logic [3:0]  fb_cmd_we;

    // Four-master instance (pointer wrap / withdraw)
    logic [3:0]   q_cmd_valid, q_cmd_ready, q_valid, q_ready;
    logic [127:0] q_cmd_addr, q_din, q_dout;
    logic [15:0]  q_cmd_we_msk;
    logic         q_fb_cmd_valid, q_fb_cmd_ready, q_fb_valid, q_fb_ready;
    logic [31:0]  q_fb_cmd_addr, q_fb_din, q_fb_dout;
    logic [3:0]   q_fb_cmd_we;

    pb_fb_arbiter #(.NMST(2)) dut2 (
        .clk(clk), .rst(rst),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_addr(m_cmd_addr), .m_cmd_we_msk(m_cmd_we_msk), .m_din(m_din),
        .m_valid(m_valid), .m_ready(m_ready), .m_dout(m_dout),
        .fb_mbus_cmd_valid(fb_cmd_valid), .fb_mbus_cmd_ready(fb_cmd_ready),
        .fb_mbus_cmd_addr(fb_cmd_addr), .fb_mbus_cmd_we_msk(fb_cmd_we),
        .fb_mbus_din(fb_din), .fb_mbus_valid(fb_valid),
        .fb_mbus_ready(fb_ready), .fb_mbus_dout(fb_dout)
    );

    pb_fb_arbiter #(.NMST(4)) dut4 (
        .clk(clk), .rst(rst),
        .m_cmd_valid(q_cmd_valid), .m_cmd_ready(q_cmd_ready),
        .m_cmd_addr(q_cmd_addr), .m_cmd_we_msk(q_cmd_we_msk), .m_din(q_din),
        .m_valid(q_valid), .m_ready(q_ready), .m_dout(q_dout),
        .fb_mbus_cmd_valid(q_fb_cmd_valid), .fb_mbus_cmd_ready(q_fb_cmd_ready),
        .fb_mbus_cmd_addr(q_fb_cmd_addr), .fb_mbus_cmd_we_msk(q_fb_cmd_we),
        .fb_mbus_din(q_fb_din), .fb_mbus_valid(q_fb_valid),
        .fb_mbus_ready(q_fb_ready), .fb_mbus_dout(q_fb_dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
    } cmd_exp_t;

    typedef struct {
        int          m;
        logic [31:0] data;
    } rsp_exp_t;

    cmd_exp_t cmd_q[$];
    rsp_exp_t rsp_q[$];

    // Monitor: every downstream command handshake and every master response
    // handshake pops one expectation.
    always @(negedge clk) begin
        cmd_exp_t   c;
        rsp_exp_t   r;
        logic [1:0] oh;
        if (!rst) begin
            if (fb_cmd_valid && fb_cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    c  = cmd_q.pop_front();
                    oh = 2'b01 << c.m;
                    chk("cmd_ready_onehot", m_cmd_ready, oh);
                    chk("cmd_addr", fb_cmd_addr, c.addr);
                    chk("cmd_we_msk", fb_cmd_we, c.we);
                    chk("cmd_din", fb_din, c.din);
                    $display("cmd  m%0d addr=0x%h we=0x%h din=0x%h", c.m, fb_cmd_addr, fb_cmd_we, fb_din);
                end
            end
            if ((m_valid & m_ready) != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    r  = rsp_q.pop_front();
                    oh = 2'b01 << r.m;
                    chk("rsp_master", m_valid, oh);
                    chk("rsp_data", m_dout[r.m*32 +: 32], r.data);
                    $display("rsp  m%0d dout=0x%h", r.m, m_dout[r.m*32 +: 32]);
                end
            end
        end
    end

    task automatic req(input int m, input logic [31:0] addr, input logic [3:0] we,
                       input logic [31:0] din, input logic [31:0] rdata, input bit exp_rsp);
        cmd_exp_t c;
        rsp_exp_t r;
        m_cmd_addr[m*32 +: 32] = addr;
        m_cmd_we_msk[m*4 +: 4] = we;
        m_din[m*32 +: 32]      = din;
        m_cmd_valid[m]         = 1'b1;
        c = '{m, addr, we, din};
        cmd_q.push_back(c);
        if (exp_rsp) begin
            r = '{m, rdata};
            rsp_q.push_back(r);
        end
    endtask

    task automatic wait_cmd(output bit ok);
        int t = 0;
        while (!fb_cmd_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        ok = fb_cmd_valid;
        chk("cmd_wait", ok, 1);
    endtask

    // Bus slave: hold cmd_ready low cs cycles, accept, then present data
    // with the master holding m_ready low for rs cycles.
    task automatic serve(input int cs, input int rs, input logic [31:0] data,
                         input logic [31:0] din_exp);
        bit ok;
        logic [1:0] g;
        wait_cmd(ok);
        if (!ok) return;
        for (int i = 0; i < cs; i++) begin
            @(posedge clk); #1;
            chk("cmd_stall_hold", {fb_cmd_valid, m_cmd_ready}, 3'b100);
        end
        fb_cmd_ready = 1'b1;
        #1;
        g = m_cmd_ready;
        @(posedge clk); #1;
        fb_cmd_ready = 1'b0;
        m_cmd_valid  = m_cmd_valid & ~g;
        chk("data_no_cmd_valid", fb_cmd_valid, 0);
        chk("din_hold_data", fb_din, din_exp);
        fb_valid = 1'b1;
        fb_dout  = data;
        if (rs > 0) m_ready = 2'b00;
        for (int i = 0; i < rs; i++) begin
            #1;
            chk("rsp_stall_hold", {m_valid, fb_ready}, {g, 1'b0});
            @(posedge clk); #1;
        end
        m_ready = 2'b11;
        @(posedge clk); #1;
        fb_valid = 1'b0;
        fb_dout  = '0;
    endtask

    task automatic chk_idle2(input string name);
        chk({name, "_hs"}, {m_cmd_ready, m_valid, fb_cmd_valid, fb_ready}, 6'b0);
        chk({name, "_addr"}, {fb_cmd_addr, fb_cmd_we}, 36'h0);
        chk({name, "_din"}, fb_din, 0);
        chk({name, "_dout"}, m_dout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1;
        m_cmd_valid = 2'b11; m_cmd_addr = '0; m_cmd_we_msk = '0; m_din = '0;
        m_ready = 2'b11; fb_cmd_ready = 1'b1; fb_valid = 1'b1; fb_dout = 32'hFFFF_FFFF;
        q_cmd_valid = '0; q_cmd_we_msk = '0; q_ready = 4'hF;
        q_fb_cmd_ready = 1'b0; q_fb_valid = 1'b0; q_fb_dout = 32'h0;
        for (int i = 0; i < 4; i++) begin
            q_cmd_addr[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h10;
            q_din[i*32 +: 32]      = 32'hD000 + 32'(i);
        end

        // Reset with busy inputs: everything must be zero.
        repeat (2) @(posedge clk);
        #1;
        chk_idle2("reset");
        m_cmd_valid = 2'b00; fb_cmd_ready = 1'b0; fb_valid = 1'b0; fb_dout = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read by m0, then ptr=1 means m1 wins a tie.
        req(0, 32'h100, 4'h0, 32'hA0A0_A0A0, 32'hDEAD_BEEF, 1);
        serve(0, 0, 32'hDEAD_BEEF, 32'hA0A0_A0A0);
        req(1, 32'h110, 4'h0, 32'hB1B1_B1B1, 32'h1111_0001, 1);
        req(0, 32'h120, 4'h0, 32'hA2A2_A2A2, 32'h1111_0002, 1);
        serve(0, 0, 32'h1111_0001, 32'hB1B1_B1B1);
        serve(0, 0, 32'h1111_0002, 32'hA2A2_A2A2);

        // Contention from reset: grants alternate 0,1,0,1...
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req(0, 32'h500 + 32'(k), 4'h0, 32'h0, 32'hC000_0000 + 32'(k), 1);
            req(1, 32'h600 + 32'(k), 4'h0, 32'h0, 32'hC100_0000 + 32'(k), 1);
            serve(0, 0, 32'hC000_0000 + 32'(k), 32'h0);
            serve(0, 0, 32'hC100_0000 + 32'(k), 32'h0);
        end

        // Write from m1 with a short command stall.
        req(1, 32'h200, 4'b1111, 32'h1234_5678, 32'h0, 1);
        serve(2, 0, 32'h0, 32'h1234_5678);

        // Back-pressure on both phases.
        req(0, 32'h300, 4'b0011, 32'hCAFE_0000, 32'h55AA_55AA, 1);
        serve(5, 3, 32'h55AA_55AA, 32'hCAFE_0000);

        // Stray downstream response while idle.
        fb_valid = 1'b1; fb_dout = 32'h9999_9999;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stray_valid_idle", {m_valid, fb_ready}, 3'b000);
        end
        fb_valid = 1'b0; fb_dout = '0;

        // Reset while waiting on the response.
        req(0, 32'h400, 4'h0, 32'h0BAD_F00D, 32'h0, 0);
        wait_cmd(ok);
        fb_cmd_ready = 1'b1;
        @(posedge clk); #1;
        fb_cmd_ready = 1'b0;
        m_cmd_valid  = 2'b00;
        chk("rst_case_in_data", {fb_cmd_valid, fb_ready}, 2'b01);
        chk("rst_case_din", fb_din, 32'h0BAD_F00D);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle2("rst_in_data");
        fb_valid = 1'b1; fb_dout = 32'h7777_7777;
        repeat (3) begin
            @(posedge clk); #1;
            chk("late_valid_after_rst", {m_valid, fb_ready}, 3'b000);
        end
        fb_valid = 1'b0; fb_dout = '0;

        // NMST=4: bring ptr to 3, then m3 withdraws in CMD.
        q_cmd_valid = 4'b0100;
        @(posedge clk); #1;
        chk("q_grant_m2", {q_fb_cmd_valid, q_fb_cmd_addr}, {1'b1, 32'h1020});
        q_fb_cmd_ready = 1'b1;
        @(posedge clk); #1;
        q_fb_cmd_ready = 1'b0; q_cmd_valid = 4'b0000;
        q_fb_valid = 1'b1; q_fb_dout = 32'h4242_4242;
        #1;
        chk("q_rsp_m2", {q_valid, q_dout[64 +: 32]}, {4'b0100, 32'h4242_4242});
        @(posedge clk); #1;
        q_fb_valid = 1'b0;
        q_cmd_valid = 4'b1001;
        @(posedge clk); #1;
        chk("q_grant_m3", {q_fb_cmd_valid, q_fb_cmd_addr}, {1'b1, 32'h1030});
        $display("q    grant m3 addr=0x%h", q_fb_cmd_addr);
        q_cmd_valid = 4'b0001;
        #1;
        chk("q_withdraw_drop", q_fb_cmd_valid, 0);
        @(posedge clk); #1;
        chk("q_withdraw_idle", {q_fb_cmd_valid, q_fb_cmd_addr}, 33'h0);
        q_cmd_valid = 4'b1001;
        @(posedge clk); #1;
        chk("q_ptr_kept_3", {q_fb_cmd_valid, q_fb_cmd_addr}, {1'b1, 32'h1030});
        q_fb_cmd_ready = 1'b1;
        @(posedge clk); #1;
        q_fb_cmd_ready = 1'b0; q_cmd_valid = 4'b0001;
        q_fb_valid = 1'b1; q_fb_dout = 32'h3333_3333;
        @(posedge clk); #1;
        q_fb_valid = 1'b0;
        @(posedge clk); #1;
        chk("q_wrap_to_m0", {q_fb_cmd_valid, q_fb_cmd_addr}, {1'b1, 32'h1000});
        $display("q    grant m0 addr=0x%h after wrap", q_fb_cmd_addr);
        q_cmd_valid = 4'b0000;
        @(posedge clk); #1;

        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
